// File: rtl/power_ctrl_if.sv
// Bus bundle for power_ctrl: two AXI-Lite slave ports and one AXI-Lite master port.
// The slave modport is the register block's view; master is the driver's view.
interface power_ctrl_if;
    logic [1:0][31:0] s_aw_addr;
    logic [1:0]       s_aw_valid;
    logic [1:0]       s_aw_ready;
    logic [1:0][31:0] s_w_data;
    logic [1:0][3:0]  s_w_strb;
    logic [1:0]       s_w_valid;
    logic [1:0]       s_w_ready;
    logic [1:0][1:0]  s_b_resp;
    logic [1:0]       s_b_valid;
    logic [1:0]       s_b_ready;
    logic [1:0][31:0] s_ar_addr;
    logic [1:0]       s_ar_valid;
    logic [1:0]       s_ar_ready;
    logic [1:0][31:0] s_r_data;
    logic [1:0][1:0]  s_r_resp;
    logic [1:0]       s_r_valid;
    logic [1:0]       s_r_ready;

    logic [31:0] m_aw_addr;
    logic        m_aw_valid;
    logic        m_aw_ready;
    logic [31:0] m_w_data;
    logic [3:0]  m_w_strb;
    logic        m_w_valid;
    logic        m_w_ready;
    logic [1:0]  m_b_resp;
    logic        m_b_valid;
    logic        m_b_ready;
    logic [31:0] m_ar_addr;
    logic        m_ar_valid;
    logic        m_ar_ready;
    logic [31:0] m_r_data;
    logic        m_r_valid;
    logic        m_r_ready;

    modport slave (
        input  s_aw_addr, s_aw_valid, s_w_data, s_w_strb, s_w_valid,
        input  s_b_ready, s_ar_addr, s_ar_valid, s_r_ready,
        output s_aw_ready, s_w_ready, s_b_resp, s_b_valid,
        output s_ar_ready, s_r_data, s_r_resp, s_r_valid,
        output m_aw_addr, m_aw_valid, m_w_data, m_w_strb, m_w_valid,
        output m_b_ready, m_ar_addr, m_ar_valid, m_r_ready,
        input  m_aw_ready, m_w_ready, m_b_resp, m_b_valid,
        input  m_ar_ready, m_r_data, m_r_valid
    );

    modport master (
        output s_aw_addr, s_aw_valid, s_w_data, s_w_strb, s_w_valid,
        output s_b_ready, s_ar_addr, s_ar_valid, s_r_ready,
        input  s_aw_ready, s_w_ready, s_b_resp, s_b_valid,
        input  s_ar_ready, s_r_data, s_r_resp, s_r_valid,
        input  m_aw_addr, m_aw_valid, m_w_data, m_w_strb, m_w_valid,
        input  m_b_ready, m_ar_addr, m_ar_valid, m_r_ready,
        output m_aw_ready, m_w_ready, m_b_resp, m_b_valid,
        output m_ar_ready, m_r_data, m_r_valid
    );
endinterface

// File: rtl/power_ctrl.sv
// Power-control register block: dual AXI-Lite slave register file and a
// delayed single-shot AXI-Lite master write into the SYSCFG region.
module power_ctrl #(
    parameter int          REG_NUM     = 16,
    parameter logic [31:0] SYSCFG_BASE = 32'h0100_0000
) (
    input logic        clk,
    input logic        rst_n,
    power_ctrl_if.slave bus
);
    localparam int IW = $clog2(REG_NUM);
    localparam logic [IW-1:0] IDX_CMD = IW'(0);
    localparam logic [IW-1:0] IDX_STS = IW'(1);
    localparam logic [IW-1:0] IDX_OFS = IW'(2);
    localparam logic [IW-1:0] IDX_DLY = IW'(10);

    typedef enum logic [1:0] {IDLE, WAIT, ADDR, RESP} state_e;

    state_e           state_q, state_d;
    logic [31:0]      cnt_q, cnt_d;
    logic             aw_done_q, aw_done_d;
    logic             w_done_q, w_done_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             en_q;
    logic [31:0]      regs_q [REG_NUM];
    logic [1:0]       b_pend_q, r_pend_q;
    logic [1:0][1:0]  b_resp_q, r_resp_q;
    logic [1:0][31:0] r_data_q;

    logic        busy;
    logic [31:0] status;
    assign busy   = state_q != IDLE;
    assign status = {29'b0, err_q, done_q, busy};

    // Port 0 wins a same-cycle write; port 1 only sees ready when port 0 is not asking.
    logic [1:0] req, wrdy, wacc;
    assign req     = bus.s_aw_valid & bus.s_w_valid & ~b_pend_q;
    assign wrdy[0] = en_q & ~b_pend_q[0];
    assign wrdy[1] = en_q & ~b_pend_q[1] & ~req[0];
    assign wacc    = req & wrdy;
    assign bus.s_aw_ready = wrdy;
    assign bus.s_w_ready  = wrdy;

    logic          wsel, wen, w_oob, w_cmd, w_sts, w_err, w_upd, launch;
    logic [31:0]   waddr, wdata, wmask, merged;
    logic [3:0]    wstrb;
    logic [IW-1:0] widx;
    assign wsel   = ~wacc[0];
    assign wen    = |wacc;
    assign waddr  = bus.s_aw_addr[wsel];
    assign wdata  = bus.s_w_data[wsel];
    assign wstrb  = bus.s_w_strb[wsel];
    assign widx   = waddr[IW+1:2];
    assign w_oob  = waddr[31:2] >= 30'(REG_NUM);
    assign w_cmd  = ~w_oob & (widx == IDX_CMD);
    assign w_sts  = ~w_oob & (widx == IDX_STS);
    assign w_err  = w_oob | (w_cmd & busy);
    assign w_upd  = wen & ~w_err & ~w_sts;
    assign launch = wen & w_cmd & ~busy;

    always_comb begin
        wmask = '0;
        for (int i = 0; i < 4; i++) wmask[8*i +: 8] = {8{wstrb[i]}};
    end
    assign merged = (regs_q[widx] & ~wmask) | (wdata & wmask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
        end else if (w_upd) begin
            regs_q[widx] <= merged;
        end
    end

    logic [1:0]       rrdy, racc, rd_oob;
    logic [1:0][31:0] rd_val;
    assign rrdy = {2{en_q}} & ~r_pend_q;
    assign racc = bus.s_ar_valid & rrdy;
    assign bus.s_ar_ready = rrdy;

    always_comb begin
        rd_val = '0;
        rd_oob = '0;
        for (int p = 0; p < 2; p++) begin
            rd_oob[p] = bus.s_ar_addr[p][31:2] >= 30'(REG_NUM);
            if (rd_oob[p])
                rd_val[p] = '0;
            else if (bus.s_ar_addr[p][IW+1:2] == IDX_STS)
                rd_val[p] = status;
            else
                rd_val[p] = regs_q[bus.s_ar_addr[p][IW+1:2]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q     <= 1'b0;
            b_pend_q <= '0;
            b_resp_q <= '0;
            r_pend_q <= '0;
            r_resp_q <= '0;
            r_data_q <= '0;
        end else begin
            en_q <= 1'b1;
            for (int p = 0; p < 2; p++) begin
                if (wacc[p]) begin
                    b_pend_q[p] <= 1'b1;
                    b_resp_q[p] <= w_err ? 2'b10 : 2'b00;
                end else if (bus.s_b_ready[p]) begin
                    b_pend_q[p] <= 1'b0;
                end
                if (racc[p]) begin
                    r_pend_q[p] <= 1'b1;
                    r_data_q[p] <= rd_val[p];
                    r_resp_q[p] <= rd_oob[p] ? 2'b10 : 2'b00;
                end else if (bus.s_r_ready[p]) begin
                    r_pend_q[p] <= 1'b0;
                end
            end
        end
    end

    assign bus.s_b_valid = b_pend_q;
    assign bus.s_b_resp  = b_resp_q;
    assign bus.s_r_valid = r_pend_q;
    assign bus.s_r_resp  = r_resp_q;
    assign bus.s_r_data  = r_data_q;

    logic aw_hs, w_hs, in_addr;
    assign in_addr        = state_q == ADDR;
    assign bus.m_aw_valid = in_addr & ~aw_done_q;
    assign bus.m_w_valid  = in_addr & ~w_done_q;
    assign bus.m_aw_addr  = in_addr ? SYSCFG_BASE + regs_q[IDX_OFS] : '0;
    assign bus.m_w_data   = in_addr ? regs_q[IDX_CMD] : '0;
    assign bus.m_w_strb   = in_addr ? 4'hF : 4'h0;
    assign bus.m_b_ready  = state_q == RESP;
    assign bus.m_ar_valid = 1'b0;
    assign bus.m_ar_addr  = '0;
    assign bus.m_r_ready  = 1'b1;
    assign aw_hs = bus.m_aw_valid & bus.m_aw_ready;
    assign w_hs  = bus.m_w_valid & bus.m_w_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        done_d    = done_q;
        err_d     = err_q;
        unique case (state_q)
            IDLE: if (launch) begin
                state_d = WAIT;
                cnt_d   = regs_q[IDX_DLY];
                done_d  = 1'b0;
                err_d   = 1'b0;
            end
            WAIT: begin
                if (cnt_q == '0) state_d = ADDR;
                else cnt_d = cnt_q - 32'd1;
            end
            ADDR: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs) w_done_d = 1'b1;
                if (aw_done_d && w_done_d) begin
                    state_d   = RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            RESP: if (bus.m_b_valid) begin
                state_d = IDLE;
                done_d  = 1'b1;
                err_d   = bus.m_b_resp != 2'b00;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    logic unused;
    assign unused = ^{bus.m_ar_ready, bus.m_r_data, bus.m_r_valid, waddr[1:0],
                      bus.s_ar_addr[0][1:0], bus.s_ar_addr[1][1:0]};
endmodule

// File: tb/tb_power_ctrl.sv
// Directed bench for power_ctrl: register table vectors plus hand-written
// sequences for launch latency, arbitration, busy rejection, errors and reset.
module tb_power_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    power_ctrl_if bus ();

    power_ctrl #(
        .REG_NUM(16),
        .SYSCFG_BASE(32'h0100_0000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int launches = 0;

    always @(posedge clk)
        if (bus.m_aw_valid && bus.m_aw_ready) launches <= launches + 1;

    typedef struct {
        bit          w;
        int          p;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] ed;
        logic [1:0]  er;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic wr(int p, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                      output logic [1:0] resp);
        bit ok = 0;
        resp = 2'b11;
        @(negedge clk);
        bus.s_aw_addr[p] = a;
        bus.s_w_data[p] = d;
        bus.s_w_strb[p] = s;
        bus.s_aw_valid[p] = 1'b1;
        bus.s_w_valid[p] = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (bus.s_aw_ready[p] && bus.s_w_ready[p]) begin
                @(negedge clk);
                if (bus.s_b_valid[p]) resp = bus.s_b_resp[p];
                ok = 1;
            end else begin
                @(negedge clk);
            end
        end
        bus.s_aw_valid[p] = 1'b0;
        bus.s_w_valid[p] = 1'b0;
        if (!ok) chk("wr_timeout", 0, 1);
    endtask

    task automatic rd(int p, logic [31:0] a, output logic [31:0] d,
                      output logic [1:0] resp);
        bit ok = 0;
        d = 32'hxxxx_xxxx;
        resp = 2'b11;
        @(negedge clk);
        bus.s_ar_addr[p] = a;
        bus.s_ar_valid[p] = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (bus.s_ar_ready[p]) begin
                @(negedge clk);
                if (bus.s_r_valid[p]) begin
                    d = bus.s_r_data[p];
                    resp = bus.s_r_resp[p];
                end
                ok = 1;
            end else begin
                @(negedge clk);
            end
        end
        bus.s_ar_valid[p] = 1'b0;
        if (!ok) chk("rd_timeout", 0, 1);
    endtask

    task automatic wait_aw();
        int n = 0;
        while (!bus.m_aw_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("aw_rise", bus.m_aw_valid, 1);
    endtask

    // Handshake aw first, then w, so each valid is seen dropping on its own.
    task automatic mserve(logic [1:0] br);
        @(negedge clk);
        bus.m_aw_ready = 1'b1;
        @(negedge clk);
        bus.m_aw_ready = 1'b0;
        chk("aw_drop", bus.m_aw_valid, 0);
        chk("w_hold", bus.m_w_valid, 1);
        bus.m_w_ready = 1'b1;
        @(negedge clk);
        bus.m_w_ready = 1'b0;
        chk("w_drop", bus.m_w_valid, 0);
        chk("m_b_ready", bus.m_b_ready, 1);
        bus.m_b_valid = 1'b1;
        bus.m_b_resp = br;
        @(negedge clk);
        bus.m_b_valid = 1'b0;
        bus.m_b_resp = 2'b00;
    endtask

    logic [31:0] d;
    logic [1:0]  r;
    int n, t0, t1, l0;

    initial begin
        bus.s_aw_addr = '0; bus.s_aw_valid = '0;
        bus.s_w_data = '0; bus.s_w_strb = '0; bus.s_w_valid = '0;
        bus.s_b_ready = 2'b11;
        bus.s_ar_addr = '0; bus.s_ar_valid = '0;
        bus.s_r_ready = 2'b11;
        bus.m_aw_ready = 0; bus.m_w_ready = 0;
        bus.m_b_resp = 0; bus.m_b_valid = 0;
        bus.m_ar_ready = 0; bus.m_r_data = 0; bus.m_r_valid = 0;

        tbl[0]  = '{1, 0, 32'h08, 32'h0000_0010, 4'hF, 32'h0, 2'b00};
        tbl[1]  = '{0, 1, 32'h08, 32'h0, 4'h0, 32'h0000_0010, 2'b00};
        tbl[2]  = '{1, 0, 32'h0C, 32'hAABB_CCDD, 4'h5, 32'h0, 2'b00};
        tbl[3]  = '{0, 0, 32'h0C, 32'h0, 4'h0, 32'h00BB_00DD, 2'b00};
        tbl[4]  = '{1, 1, 32'h04, 32'hFFFF_FFFF, 4'hF, 32'h0, 2'b00};
        tbl[5]  = '{0, 1, 32'h04, 32'h0, 4'h0, 32'h0, 2'b00};
        tbl[6]  = '{1, 1, 32'h40, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b10};
        tbl[7]  = '{0, 0, 32'h40, 32'h0, 4'h0, 32'h0, 2'b10};
        tbl[8]  = '{0, 1, 32'h00, 32'h0, 4'h0, 32'h0, 2'b00};
        tbl[9]  = '{1, 0, 32'h3C, 32'h7700_0000, 4'h8, 32'h0, 2'b00};
        tbl[10] = '{0, 1, 32'h3C, 32'h0, 4'h0, 32'h7700_0000, 2'b00};
        tbl[11] = '{1, 0, 32'h08, 32'h0, 4'hF, 32'h0, 2'b00};
        tbl[12] = '{0, 0, 32'h08, 32'h0, 4'h0, 32'h0, 2'b00};

        repeat (30) @(posedge clk);
        #1;
        chk("rst_aw_ready", 32'(bus.s_aw_ready), 0);
        chk("rst_ar_ready", 32'(bus.s_ar_ready), 0);
        chk("rst_b_valid", 32'(bus.s_b_valid), 0);
        chk("rst_r_valid", 32'(bus.s_r_valid), 0);
        chk("rst_m_aw_valid", bus.m_aw_valid, 0);
        chk("rst_m_r_ready", bus.m_r_ready, 1);
        chk("rst_m_ar_valid", bus.m_ar_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 16; i++) begin
                rd(p, 32'(i * 4), d, r);
                chk("rst_reg", d, 0);
                chk("rst_resp", 32'(r), 0);
            end

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].w) begin
                wr(tbl[i].p, tbl[i].a, tbl[i].d, tbl[i].s, r);
                chk($sformatf("vec%0d_wresp", i), 32'(r), 32'(tbl[i].er));
            end else begin
                rd(tbl[i].p, tbl[i].a, d, r);
                chk($sformatf("vec%0d_rdata", i), d, tbl[i].ed);
                chk($sformatf("vec%0d_rresp", i), 32'(r), 32'(tbl[i].er));
            end
        end

        wr(0, 32'h28, 32'h1F4, 4'hF, r);
        chk("dly_wresp", 32'(r), 0);
        wr(0, 32'h00, 32'h1234_5678, 4'hF, r);
        chk("cmd_wresp", 32'(r), 0);
        n = 0;
        while (!bus.m_aw_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("launch_latency", n, 501);
        chk("m_w_valid", bus.m_w_valid, 1);
        chk("m_aw_addr", bus.m_aw_addr, 32'h0100_0000);
        chk("m_w_data", bus.m_w_data, 32'h1234_5678);
        chk("m_w_strb", 32'(bus.m_w_strb), 32'hF);
        rd(1, 32'h04, d, r);
        chk("status_busy", d, 32'h1);
        mserve(2'b00);
        rd(0, 32'h04, d, r);
        chk("status_done", d, 32'h2);

        @(negedge clk);
        bus.s_aw_addr = {32'h18, 32'h14};
        bus.s_w_data = {32'h6666_6666, 32'h5555_5555};
        bus.s_w_strb = {4'hF, 4'hF};
        bus.s_aw_valid = 2'b11;
        bus.s_w_valid = 2'b11;
        t0 = -1;
        t1 = -1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (bus.s_b_valid[0] && t0 < 0) begin
                t0 = c;
                bus.s_aw_valid[0] = 0;
                bus.s_w_valid[0] = 0;
            end
            if (bus.s_b_valid[1] && t1 < 0) begin
                t1 = c;
                bus.s_aw_valid[1] = 0;
                bus.s_w_valid[1] = 0;
            end
        end
        bus.s_aw_valid = 2'b00;
        bus.s_w_valid = 2'b00;
        chk("arb_p0_b", t0, 1);
        chk("arb_p1_b", t1, 2);
        rd(1, 32'h14, d, r);
        chk("arb_reg5", d, 32'h5555_5555);
        rd(0, 32'h18, d, r);
        chk("arb_reg6", d, 32'h6666_6666);

        wr(1, 32'h28, 32'd20, 4'hF, r);
        l0 = launches;
        wr(0, 32'h00, 32'hA, 4'hF, r);
        chk("cmd_a_resp", 32'(r), 0);
        wr(1, 32'h00, 32'hB, 4'hF, r);
        chk("cmd_busy_resp", 32'(r), 32'h2);
        rd(0, 32'h00, d, r);
        chk("cmd_unchanged", d, 32'hA);
        wait_aw();
        chk("busy_m_w_data", bus.m_w_data, 32'hA);
        mserve(2'b00);
        repeat (40) @(negedge clk);
        chk("single_launch", launches - l0, 1);

        wr(0, 32'h00, 32'h55, 4'hF, r);
        wait_aw();
        mserve(2'b10);
        rd(1, 32'h04, d, r);
        chk("status_err", d, 32'h6);

        wr(0, 32'h00, 32'h77, 4'hF, r);
        wait_aw();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_aw_drop", bus.m_aw_valid, 0);
        chk("async_w_drop", bus.m_w_valid, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rd(0, 32'h04, d, r);
        chk("post_rst_status", d, 0);
        rd(1, 32'h28, d, r);
        chk("post_rst_delay", d, 0);
        repeat (5) @(negedge clk);
        chk("post_rst_no_aw", bus.m_aw_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
